// File: rtl/fetch_stage.sv
// Instruction fetch: registered PC drives a combinational imem and fills an IF/ID register; first word 2 edges after reset, 1 instr/cycle.
// Backpressure: id_ready low stalls PC and id_* in place; redirects flush and take priority; a misaligned redirect parks the stage in ERR.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_pc,
  input  logic [WIDTH-1:0] imem_ins,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_ins,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic             fetch_err,
  output logic [31:0]      fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             misaligned;
  logic             load;
  logic             take_redirect;
  logic             capture;
  logic             set_err;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign load       = !id_valid || id_ready;
  assign pc_plus4   = pc + {{(WIDTH-3){1'b0}}, 3'd4};
  assign imem_pc    = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = (redirect_valid && misaligned) ? ERR : RUN;
      RUN:     state_nxt = (redirect_valid && misaligned) ? ERR : RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = BOOT;
    endcase
  end

  // Redirect outranks load; ERR ignores everything until reset.
  always_comb begin
    take_redirect = 1'b0;
    capture       = 1'b0;
    set_err       = 1'b0;
    case (state)
      BOOT: begin
        if (redirect_valid) begin
          take_redirect = !misaligned;
          set_err       = misaligned;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          take_redirect = !misaligned;
          set_err       = misaligned;
        end else if (load) begin
          capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_ins      <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (take_redirect) begin
        pc <= redirect_pc;
      end else if (capture) begin
        pc <= pc_plus4;
      end
      if (take_redirect || set_err) begin
        id_valid <= 1'b0;
      end else if (capture) begin
        id_valid <= 1'b1;
      end
      if (capture) begin
        id_ins      <= imem_ins;
        id_pc       <= pc;
        id_pc_plus4 <= pc_plus4;
      end
      if (set_err) begin
        fetch_err <= 1'b1;
      end
    end
  end

  // Decode owns a word once it handshakes, even on the edge a redirect flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (id_valid && id_ready) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (reset PC 0 and 0xFFFFFFFC) share stimulus and
// are compared every cycle against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        rdy = 1'b1;

  logic [31:0] pc_a, ins_a, id_ins_a, id_pc_a, pc4_a, cnt_a;
  logic        vld_a, err_a;
  logic [31:0] pc_b, ins_b, id_ins_b, id_pc_b, pc4_b, cnt_b;
  logic        vld_b, err_b;

  logic [31:0] mem [32];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] frozen;

  typedef struct packed {
    logic        boot;
    logic        err;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } mdl_t;
  mdl_t m [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a < 32'h80) return mem[a[6:2]];
    return a ^ 32'hDEADBEEF;
  endfunction

  always_comb ins_a = memf(pc_a);
  always_comb ins_b = memf(pc_b);

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_pc(pc_a), .imem_ins(ins_a),
    .redirect_valid(rv), .redirect_pc(rpc), .id_ready(rdy),
    .id_valid(vld_a), .id_ins(id_ins_a), .id_pc(id_pc_a),
    .id_pc_plus4(pc4_a), .fetch_err(err_a), .fetch_count(cnt_a)
  );

  fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFFFFFC)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_pc(pc_b), .imem_ins(ins_b),
    .redirect_valid(rv), .redirect_pc(rpc), .id_ready(rdy),
    .id_valid(vld_b), .id_ins(id_ins_b), .id_pc(id_pc_b),
    .id_pc_plus4(pc4_b), .fetch_err(err_b), .fetch_count(cnt_b)
  );

  function automatic mdl_t mdl_reset(input logic [31:0] rpc0);
    mdl_t r;
    r = '0;
    r.boot = 1'b1;
    r.pc   = rpc0;
    return r;
  endfunction

  // One clock edge of the fetch contract, applied to the pre-edge state.
  function automatic mdl_t mdl_next(input mdl_t o, input logic v, input logic [31:0] t,
                                    input logic r);
    mdl_t n;
    n = o;
    if (o.vld && r) n.cnt = o.cnt + 1;
    if (o.err) return n;
    n.boot = 1'b0;
    if (v) begin
      n.vld = 1'b0;
      if (t[1:0] != 2'b00) n.err = 1'b1;
      else n.pc = t;
    end else if (!o.boot && (!o.vld || r)) begin
      n.ins = memf(o.pc);
      n.ipc = o.pc;
      n.pc4 = o.pc + 4;
      n.vld = 1'b1;
      n.pc  = o.pc + 4;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("a_imem_pc", pc_a, m[0].pc);
    chk("a_id_valid", {31'd0, vld_a}, {31'd0, m[0].vld});
    chk("a_fetch_err", {31'd0, err_a}, {31'd0, m[0].err});
    chk("a_fetch_count", cnt_a, m[0].cnt);
    chk("a_id_ins", id_ins_a, m[0].ins);
    chk("a_id_pc", id_pc_a, m[0].ipc);
    chk("a_id_pc_plus4", pc4_a, m[0].pc4);
    chk("b_imem_pc", pc_b, m[1].pc);
    chk("b_id_valid", {31'd0, vld_b}, {31'd0, m[1].vld});
    chk("b_fetch_err", {31'd0, err_b}, {31'd0, m[1].err});
    chk("b_fetch_count", cnt_b, m[1].cnt);
    chk("b_id_ins", id_ins_b, m[1].ins);
    chk("b_id_pc", id_pc_b, m[1].ipc);
    chk("b_id_pc_plus4", pc4_b, m[1].pc4);
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = mdl_next(m[i], rv, rpc, rdy);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    m[0] = mdl_reset(32'h0);
    m[1] = mdl_reset(32'hFFFFFFFC);
  endtask

  initial begin
    mem[0] = 32'h02800093;
    mem[1] = 32'h02a00113;
    mem[2] = 32'h002081b3;
    for (int i = 3; i < 32; i++) mem[i] = $urandom;
    model_reset();

    // Reset state and boot sequence
    #12;
    check_all();
    chk("rst_imem_pc_b", pc_b, 32'hFFFFFFFC);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("boot_edge1_no_valid", {31'd0, vld_a}, 32'd0);
    step();
    chk("boot_first_ins", id_ins_a, 32'h02800093);
    chk("boot_first_pc", id_pc_a, 32'h0);
    chk("wrap_id_pc", id_pc_b, 32'hFFFFFFFC);
    chk("wrap_id_pc_plus4", pc4_b, 32'h0);
    step();
    chk("seq_ins1", id_ins_a, 32'h02a00113);
    chk("seq_pc1", id_pc_a, 32'h4);
    chk("wrap_next_pc", id_pc_b, 32'h0);

    // Stall while id_pc=4
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ins", id_ins_a, 32'h02a00113);
      chk("stall_pc", id_pc_a, 32'h4);
      chk("stall_imem_pc", pc_a, 32'h8);
      chk("stall_count", cnt_a, 32'd1);
    end
    rdy = 1'b1;
    step();
    chk("release_pc", id_pc_a, 32'h8);
    chk("release_ins", id_ins_a, 32'h002081b3);
    step();
    chk("three_transfers", cnt_a, 32'd3);

    // Aligned redirect flushes the held word but still counts it
    rv = 1'b1; rpc = 32'h10;
    step();
    chk("redir_count", cnt_a, 32'd4);
    chk("redir_flush", {31'd0, vld_a}, 32'd0);
    chk("redir_imem_pc", pc_a, 32'h10);
    rv = 1'b0;
    step();
    chk("redir_target_pc", id_pc_a, 32'h10);
    chk("redir_target_ins", id_ins_a, mem[4]);
    chk("redir_target_vld", {31'd0, vld_a}, 32'd1);

    // Randomized traffic with occasional aligned redirects
    for (int k = 0; k < 300; k++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 : ($urandom_range(0, 31) << 2);
      step();
    end
    rv = 1'b0;
    rdy = 1'b1;
    step();

    // Misaligned redirect parks both instances in ERR
    rv = 1'b1; rpc = 32'h12;
    frozen = m[0].pc;
    step();
    chk("mis_err", {31'd0, err_a}, 32'd1);
    chk("mis_vld", {31'd0, vld_a}, 32'd0);
    chk("mis_pc_frozen", pc_a, frozen);
    rpc = 32'h20;
    for (int k = 0; k < 3; k++) begin
      rdy = $urandom_range(0, 1);
      step();
      chk("err_ignore_redirect", pc_a, frozen);
      chk("err_sticky", {31'd0, err_a}, 32'd1);
    end
    rv = 1'b0;

    // Reset out of ERR, asserted between edges
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("err_cleared", {31'd0, err_a}, 32'd0);
    chk("err_rst_pc", pc_a, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("rerun_vld", {31'd0, vld_a}, 32'd1);

    // Async reset mid-run with a valid word held
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_vld", {31'd0, vld_a}, 32'd0);
    chk("async_count", cnt_a, 32'd0);
    chk("async_id_pc", id_pc_a, 32'd0);
    chk("async_pc_b", pc_b, 32'hFFFFFFFC);
    @(negedge clk) rst_n = 1'b1;
    step();
    step();
    chk("post_rst_ins", id_ins_a, 32'h02800093);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
